// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter -- iterative 32-bit multiply/divide unit for the HI/LO pair.
//
// Performs MULT, MULTU, DIV and DIVU with one shift-add (multiply) or
// restoring-subtract (divide) step per clock. The result is written to HI/LO
// through a one-cycle write-enable pulse.
//
// Handshake: start is a request pulse that is honoured only while the unit is
// IDLE (busy=0). There is no ready/backpressure: a start seen while busy is
// dropped, not queued. Operands are captured on the accepting edge. done,
// hi_w and lo_w rise together for exactly one cycle, and hi_wdata/lo_wdata
// are valid in that cycle and held until the next done.
//
// Timing (start sampled at edge N):
//   edge N       : operands captured, CALC entered, busy rises
//   edges N+1..32: 32 iterations (counter 0..31)
//   edge N+33    : sign fix-up, result registered, DONE entered, done rises
//   edge N+34    : back to IDLE, busy and done fall
//
// Ports:
//   clk          in   1  clock, rising edge
//   HI_LO_rst    in   1  asynchronous active-high reset
//   start        in   1  request pulse, sampled only in IDLE
//   op           in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a            in  32  multiplicand / dividend (rs)
//   b            in  32  multiplier / divisor (rt)
//   busy         out  1  high whenever the FSM is not IDLE
//   done         out  1  one-cycle result pulse
//   hi_wdata     out 32  HI result (product[63:32] or remainder)
//   lo_wdata     out 32  LO result (product[31:0] or quotient)
//   hi_w, lo_w   out  1  HI/LO write enables, high only in the done cycle
//   dbg_state_o  out  2  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//   dbg_cnt_o    out  6  iteration counter
// ---------------------------------------------------------------------------
module mdu_iter (
    input  logic        clk,
    input  logic        HI_LO_rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        hi_w,
    output logic        lo_w,
    output logic [1:0]  dbg_state_o,
    output logic [5:0]  dbg_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value at which the 32 iterations are complete and the
    // fix-up/result cycle runs.
    localparam logic [5:0] LAST_CNT = 6'd32;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        hi_w_q;
    logic        lo_w_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_div_q;   // divide (1) or multiply (0)
    logic        dz_q;       // divide by zero
    logic        neg_res_q;  // negate product / quotient at the end
    logic        neg_rem_q;  // negate remainder at the end
    logic [31:0] a_raw_q;    // original dividend, returned as HI on div-by-0
    logic [31:0] bmag_q;     // multiplicand or divisor magnitude
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits shifting into quotient}.
    logic [63:0] acc_q;

    // ---------------------------------------------------------------------
    // Operand preparation (used only on the accepting edge)
    // ---------------------------------------------------------------------
    logic        in_signed;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    always_comb begin
        in_signed = ~op[0];
        a_neg_in  = in_signed & a[31];
        b_neg_in  = in_signed & b[31];
        // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
        a_mag_in  = a_neg_in ? (32'd0 - a) : a;
        b_mag_in  = b_neg_in ? (32'd0 - b) : b;
    end

    // ---------------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_d;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the
        // current multiplier LSB is set, then shift right keeping the carry.
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        // Restoring divide: bring the next dividend bit into the remainder
        // and try subtracting the divisor. The shifted remainder can reach
        // 33 bits, but then the subtraction always succeeds and the new
        // remainder is below the divisor, so 32 bits are kept.
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, bmag_q};
        if (div_diff[32]) begin
            div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
        end else begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end

        acc_d = is_div_q ? div_next : mul_next;
    end

    // ---------------------------------------------------------------------
    // Result fix-up after the last iteration
    // ---------------------------------------------------------------------
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    always_comb begin
        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

        if (!is_div_q) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
        end else if (dz_q) begin
            // Divide by zero returns all-ones quotient and the raw dividend,
            // independent of signedness.
            hi_d = a_raw_q;
            lo_d = 32'hFFFF_FFFF;
        end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end
    end

    // ---------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge HI_LO_rst) begin
        if (HI_LO_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_w_q    <= 1'b0;
            lo_w_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_raw_q   <= 32'd0;
            bmag_q    <= 32'd0;
            acc_q     <= 64'd0;
        end else begin
            // Pulses default low; only the CALC->DONE transition raises them.
            done_q <= 1'b0;
            hi_w_q <= 1'b0;
            lo_w_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= 6'd0;
                        is_div_q  <= op[1];
                        dz_q      <= op[1] & (b == 32'd0);
                        neg_res_q <= a_neg_in ^ b_neg_in;
                        neg_rem_q <= a_neg_in;
                        a_raw_q   <= a;
                        bmag_q    <= b_mag_in;
                        acc_q     <= {32'd0, a_mag_in};
                    end
                end

                CALC: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        hi_w_q  <= 1'b1;
                        lo_w_q  <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi_w        = hi_w_q;
    assign lo_w        = lo_w_q;
    assign hi_wdata    = hi_q;
    assign lo_wdata    = lo_q;
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule
